// File: rtl/line_draw_pkg.sv
// Shared types and constants for the Bresenham line engine.
package line_draw_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_FINISH} state_t;

  localparam int COORD_W_DEF  = 9;
  localparam int COLOUR_W_DEF = 8;
  // Two guard bits let 2*err and the signed deltas fit without overflow.
  localparam int ERR_W_EXTRA  = 2;

  function automatic int err_w(input int coord_w);
    return coord_w + ERR_W_EXTRA;
  endfunction

endpackage

// File: rtl/line_step.sv
// One Bresenham step: next x/y/err from the current point and error term.
module line_step
  import line_draw_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int EW      = err_w(COORD_W)
) (
  input  logic [COORD_W-1:0]   cur_x,
  input  logic [COORD_W-1:0]   cur_y,
  input  logic signed [EW-1:0] err,
  input  logic signed [EW-1:0] dx,
  input  logic signed [EW-1:0] dy,
  input  logic                 sx_neg,
  input  logic                 sy_neg,
  output logic [COORD_W-1:0]   nxt_x,
  output logic [COORD_W-1:0]   nxt_y,
  output logic signed [EW-1:0] nxt_err
);

  logic signed [EW:0] e2, dx_w, dy_w;
  logic               x_step, y_step;

  assign e2     = $signed({err, 1'b0});
  assign dx_w   = $signed({dx[EW-1], dx});
  assign dy_w   = $signed({dy[EW-1], dy});
  assign x_step = (e2 >= dy_w);
  assign y_step = (e2 <= dx_w);

  assign nxt_err = err + (x_step ? dy : '0) + (y_step ? dx : '0);
  assign nxt_x   = !x_step ? cur_x : (sx_neg ? cur_x - COORD_W'(1) : cur_x + COORD_W'(1));
  assign nxt_y   = !y_step ? cur_y : (sy_neg ? cur_y - COORD_W'(1) : cur_y + COORD_W'(1));

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser streaming pixels over a valid/ready handshake.
// Optional off-screen clipping is enabled with `define LINE_DRAW_CLIP_EN.
module line_draw_engine
  import line_draw_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int X_MAX    = 319,
  parameter int Y_MAX    = 239
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  input  logic [COORD_W-1:0]  x1,
  input  logic [COORD_W-1:0]  y1,
  input  logic [COORD_W-1:0]  x2,
  input  logic [COORD_W-1:0]  y2,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic [COLOUR_W-1:0] pix_colour
);

  localparam int EW = err_w(COORD_W);
  localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

  state_t                state;
  logic [COORD_W-1:0]    cx, cy, ex, ey, nx, ny;
  logic [COLOUR_W-1:0]   col;
  logic signed [EW-1:0]  err, dx, dy, nerr;
  logic signed [EW-1:0]  dxs, dys, adx, ady;
  logic                  sx_neg, sy_neg;
  logic                  cur_vis, nxt_vis, fire, at_end;

  function automatic logic on_screen(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x <= XM) && (y <= YM);
  endfunction

`ifdef LINE_DRAW_CLIP_EN
  assign cur_vis = on_screen(cx, cy);
  assign nxt_vis = on_screen(nx, ny);
`else
  // Bounds are evaluated but never suppress a pixel in this build.
  assign cur_vis = 1'b1 | on_screen(cx, cy);
  assign nxt_vis = 1'b1 | on_screen(nx, ny);
`endif

  assign dxs = $signed({2'b00, ex}) - $signed({2'b00, cx});
  assign dys = $signed({2'b00, ey}) - $signed({2'b00, cy});
  assign adx = dxs[EW-1] ? -dxs : dxs;
  assign ady = dys[EW-1] ? -dys : dys;

  // Clipped points carry pix_valid=0 and advance without waiting for ready.
  assign fire   = (state == S_DRAW) && (!pix_valid || pix_ready);
  assign at_end = (cx == ex) && (cy == ey);

  line_step #(.COORD_W(COORD_W), .EW(EW)) u_step (
    .cur_x(cx), .cur_y(cy), .err(err), .dx(dx), .dy(dy),
    .sx_neg(sx_neg), .sy_neg(sy_neg),
    .nxt_x(nx), .nxt_y(ny), .nxt_err(nerr)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      ex        <= '0;
      ey        <= '0;
      col       <= '0;
      err       <= '0;
      dx        <= '0;
      dy        <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cx    <= x1;
          cy    <= y1;
          ex    <= x2;
          ey    <= y2;
          col   <= colour;
          busy  <= 1'b1;
          state <= S_SETUP;
        end
        S_SETUP: begin
          dx        <= adx;
          dy        <= -ady;
          err       <= adx - ady;
          sx_neg    <= dxs[EW-1];
          sy_neg    <= dys[EW-1];
          pix_valid <= cur_vis;
          state     <= S_DRAW;
        end
        S_DRAW: if (fire) begin
          if (at_end) begin
            pix_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_FINISH;
          end else begin
            cx        <= nx;
            cy        <= ny;
            err       <= nerr;
            pix_valid <= nxt_vis;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pix_x      = cx;
  assign pix_y      = cy;
  assign pix_colour = col;

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed table-driven bench for line_draw_engine.
module tb_line_draw_engine;

  logic       HCLK = 1'b0;
  logic       HRESET, start, pix_ready;
  logic [8:0] x1, y1, x2, y2;
  logic [7:0] colour;
  logic       busy, done, pix_valid;
  logic [8:0] pix_x, pix_y;
  logic [7:0] pix_colour;

  int n_chk = 0;
  int n_pass = 0;

  always #5 HCLK = ~HCLK;

  line_draw_engine dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .colour(colour),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour)
  );

  typedef struct {
    int       x1, y1, x2, y2, col;
    logic [3:0] pat;
    int       n;
    int       ex[12];
    int       ey[12];
  } vec_t;

  vec_t vecs[6];
  int px[$];
  int py[$];
  int first_valid, first_xfer, last_xfer, n_done, done_c, stab_err, col_err, busy_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_line(input vec_t v);
    logic       hold;
    logic [8:0] hx, hy;
    logic [7:0] hc;
    hold = 1'b0; hx = '0; hy = '0; hc = '0;
    px.delete(); py.delete();
    first_valid = -1; first_xfer = -1; last_xfer = -1;
    n_done = 0; done_c = -1; stab_err = 0; col_err = 0; busy_err = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge HCLK);
      start = (c == 0) || (c == 1);   // second pulse lands in SETUP
      if (c == 0) begin
        x1 = 9'(v.x1); y1 = 9'(v.y1); x2 = 9'(v.x2); y2 = 9'(v.y2); colour = 8'(v.col);
      end else if (c == 1) begin
        x1 = 9'd100; y1 = 9'd200; x2 = 9'd50; y2 = 9'd17; colour = 8'h3C;
      end
      pix_ready = v.pat[c % 4];
      if (hold && (pix_x != hx || pix_y != hy || pix_colour != hc)) stab_err++;
      hold = pix_valid && !pix_ready;
      hx = pix_x; hy = pix_y; hc = pix_colour;
      if (pix_valid && first_valid < 0) first_valid = c;
      if (pix_valid && pix_ready) begin
        px.push_back(int'(pix_x));
        py.push_back(int'(pix_y));
        if (pix_colour != 8'(v.col)) col_err++;
        if (first_xfer < 0) first_xfer = c;
        last_xfer = c;
      end
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
        start = 1'b1;                 // start during FINISH must be ignored
      end
      if (done_c >= 0 && c > done_c && busy) busy_err++;
      if (done_c >= 0 && c == done_c + 4) break;
    end
    @(negedge HCLK);
    start = 1'b0; pix_ready = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; colour = '0;

    vecs[0] = '{x1:0,  y1:0,  x2:4,  y2:0, col:8'hA5, pat:4'b1111, n:5,
               ex:'{0,1,2,3,4,0,0,0,0,0,0,0}, ey:'{0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[1] = '{x1:10, y1:10, x2:8,  y2:5, col:8'h11, pat:4'b1111, n:6,
               ex:'{10,10,9,9,8,8,0,0,0,0,0,0}, ey:'{10,9,8,7,6,5,0,0,0,0,0,0}};
    vecs[2] = '{x1:0,  y1:0,  x2:3,  y2:3, col:8'h5A, pat:4'b1001, n:4,
               ex:'{0,1,2,3,0,0,0,0,0,0,0,0}, ey:'{0,1,2,3,0,0,0,0,0,0,0,0}};
    vecs[3] = '{x1:7,  y1:7,  x2:7,  y2:7, col:8'hFF, pat:4'b1111, n:1,
               ex:'{7,0,0,0,0,0,0,0,0,0,0,0}, ey:'{7,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[4] = '{x1:0,  y1:0,  x2:5,  y2:2, col:8'h42, pat:4'b1111, n:6,
               ex:'{0,1,2,3,4,5,0,0,0,0,0,0}, ey:'{0,0,1,1,2,2,0,0,0,0,0,0}};
`ifdef LINE_DRAW_CLIP_EN
    vecs[5] = '{x1:315, y1:0, x2:325, y2:0, col:8'h81, pat:4'b1111, n:5,
               ex:'{315,316,317,318,319,0,0,0,0,0,0,0}, ey:'{0,0,0,0,0,0,0,0,0,0,0,0}};
`else
    vecs[5] = '{x1:315, y1:0, x2:325, y2:0, col:8'h81, pat:4'b1111, n:11,
               ex:'{315,316,317,318,319,320,321,322,323,324,325,0}, ey:'{0,0,0,0,0,0,0,0,0,0,0,0}};
`endif

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_xy", int'({pix_x, pix_y}), 0);
    chk("rst_colour", int'(pix_colour), 0);
    HRESET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_line(vecs[i]);
      chk($sformatf("v%0d_count", i), px.size(), vecs[i].n);
      for (int k = 0; k < vecs[i].n && k < px.size(); k++) begin
        chk($sformatf("v%0d_px%0d", i, k), px[k], vecs[i].ex[k]);
        chk($sformatf("v%0d_py%0d", i, k), py[k], vecs[i].ey[k]);
      end
      chk($sformatf("v%0d_first_latency", i), first_valid, 2);
      chk($sformatf("v%0d_done_pulses", i), n_done, 1);
      chk($sformatf("v%0d_colour_err", i), col_err, 0);
      chk($sformatf("v%0d_stable_err", i), stab_err, 0);
      chk($sformatf("v%0d_busy_after_done", i), busy_err, 0);
      if (vecs[i].pat == 4'b1111 && vecs[i].n > 1)
        chk($sformatf("v%0d_throughput", i), last_xfer - first_xfer, vecs[i].n - 1);
      if (vecs[i].pat == 4'b1111 && vecs[i].n == px.size())
        chk($sformatf("v%0d_done_timing", i), done_c, first_valid + vecs[i].n);
    end

    // Abort (0,0)->(9,0) with reset after the third transfer.
    begin
      int xf, nd, nv;
      xf = 0; nd = 0; nv = 0;
      for (int c = 0; c < 40 && xf < 3; c++) begin
        @(negedge HCLK);
        start = (c == 0);
        x1 = 9'd0; y1 = 9'd0; x2 = 9'd9; y2 = 9'd0; colour = 8'h77;
        pix_ready = 1'b1;
        if (pix_valid && pix_ready) xf++;
      end
      chk("abort_reached_3", xf, 3);
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      chk("abort_valid", int'(pix_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_xy", int'({pix_x, pix_y}), 0);
      for (int c = 0; c < 10; c++) begin
        @(negedge HCLK);
        if (done) nd++;
        if (pix_valid) nv++;
      end
      chk("abort_no_done", nd, 0);
      chk("abort_no_pixels", nv, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_draw_engine.md
LINE_DRAW_ENGINE -- requirements
Module: line_draw_engine

Interface
REQ-001 SHALL have parameter COORD_W, default 9, coordinate width in bits.
REQ-002 SHALL have parameter COLOUR_W, default 8, pixel colour width in bits.
REQ-003 SHALL have parameters X_MAX, default 319, and Y_MAX, default 239, giving the last visible column and row.
REQ-004 SHALL have port HCLK  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  line request, sampled in IDLE only.
REQ-007 SHALL have ports x1, y1, x2, y2  input  COORD_W each  unsigned endpoints, from the SoC registers.
REQ-008 SHALL have port colour  input  COLOUR_W  line colour.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have ports pix_valid (output, 1) and pix_ready (input, 1), forming the pixel-stream handshake toward the framebuffer/VGA stage.
REQ-012 SHALL have ports pix_x, pix_y (output, COORD_W) and pix_colour (output, COLOUR_W), carrying the current pixel.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, DRAW and FINISH.
REQ-014 IDLE with start=1 SHALL capture x1, y1, x2, y2 and colour, then go to SETUP; inputs changing later SHALL have no effect on the line in progress.
REQ-015 SETUP SHALL compute dx=|x2-x1|, dy=-|y2-y1|, sx/sy=+1/-1 and err=dx+dy in signed COORD_W+2 arithmetic, then go to DRAW.
REQ-016 In DRAW, pix_valid=1 SHALL present the current point; the first pixel (x1,y1) appears 2 cycles after the start cycle.
REQ-017 A pixel transfer SHALL occur only on a cycle with pix_valid && pix_ready; while pix_ready=0, pix_x, pix_y and pix_colour SHALL hold stable.
REQ-018 On each transfer SHALL apply the Bresenham step: e2=2*err; if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy; both updates may occur in one cycle.
REQ-019 A transfer of the point equal to (x2,y2) SHALL end the line and go to FINISH; pixels are emitted in order from endpoint 1 to endpoint 2, inclusive.
REQ-020 FINISH SHALL assert done for exactly one cycle and return to IDLE; start in that cycle SHALL be ignored.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 When x1==x2 and y1==y2, exactly one pixel SHALL be emitted.
REQ-023 Sustained throughput SHALL be one pixel per cycle when pix_ready is held at 1.

Reset
REQ-024 HRESET=1 SHALL force IDLE, with busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0 and pix_colour=0 after the next edge.
REQ-025 Reset during DRAW SHALL abort the line, with no further pixels and no done pulse.

Configuration
REQ-026 With LINE_DRAW_CLIP_EN defined, points with x>X_MAX or y>Y_MAX SHALL not raise pix_valid, and the stepper SHALL advance through them at one per cycle without handshake; if the end point is clipped, done SHALL still pulse.
REQ-027 Without LINE_DRAW_CLIP_EN, every point SHALL be emitted regardless of X_MAX/Y_MAX.

Structure
REQ-028 Package line_draw_pkg SHALL hold the FSM state enum typedef, the default COORD_W and COLOUR_W values, and the signed error width constant (COORD_W+2).
REQ-029 The combinational error/step update (e2 compare, next x/y/err) SHALL be a sub-module line_step; the FSM, capture and handshake logic stay in line_draw_engine.

Verification
REQ-030 Horizontal line (0,0)->(4,0) with pix_ready=1 -> pixels x=0,1,2,3,4 at y=0 on 5 consecutive cycles, then done pulses once.
REQ-031 Steep reverse line (10,10)->(8,5) -> 6 pixels with y=10 down to 5, x non-increasing, the last pixel (8,5).
REQ-032 Line (0,0)->(3,3), pix_ready toggling 1,0,0,1,... -> exactly 4 transfers, outputs stable while ready=0, no duplicates.
REQ-033 Single point (7,7) -> exactly 1 pixel (7,7), then done; a start pulsed during busy is ignored.
REQ-034 Line (315,0)->(325,0): with LINE_DRAW_CLIP_EN -> 5 pixels x=315..319 plus done; without it -> 11 pixels.
REQ-035 HRESET asserted after the 3rd pixel of (0,0)->(9,0) -> pix_valid=0 and busy=0 next cycle, with no done pulse.
